multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control unit for a multicycle MIPS-like datapath.
//                A six-state FSM (IF, ID, EXE, MEM, WB, HALT) steps each
//                instruction through only the states it needs, and a
//                combinational decoder drives the datapath selects from
//                the instruction opcode.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK        in   1  rising-edge clock
//    Reset      in   1  synchronous active-high reset, returns FSM to IF
//    opcode     in   6  opcode field of IR, stable from ID until next IF
//    zero       in   1  ALU zero flag, used for branch resolution in EXE
//    State      out  3  current FSM state
//    PCWre      out  1  PC write enable (last state of each instruction)
//    IRWre      out  1  IR write enable (IF only)
//    RegWre     out  1  register file write enable (WB only)
//    mRD        out  1  data memory read (MEM of lw)
//    mWR        out  1  data memory write (MEM of sw)
//    ALUSrcA    out  1  1 = shift amount, 0 = ReadData1
//    ALUSrcB    out  1  1 = extended immediate, 0 = ReadData2
//    ALUop      out  3  ALU operation select
//    ExtSel     out  1  1 = sign-extend, 0 = zero-extend
//    RegDst     out  1  1 = rd, 0 = rt
//    DBDataSrc  out  1  1 = memory data, 0 = ALU result
//    PCSrc      out  2  00 PC+4, 01 branch target, 10 jump target
// ============================================================================
module multicycle_control (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   output logic [2:0] State,
   output logic       PCWre,
   output logic       IRWre,
   output logic       RegWre,
   output logic       mRD,
   output logic       mWR,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUop,
   output logic       ExtSel,
   output logic       RegDst,
   output logic       DBDataSrc,
   output logic [1:0] PCSrc
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [2:0] c_ST_IF   = 3'b000;
   localparam logic [2:0] c_ST_ID   = 3'b001;
   localparam logic [2:0] c_ST_EXE  = 3'b010;
   localparam logic [2:0] c_ST_MEM  = 3'b011;
   localparam logic [2:0] c_ST_WB   = 3'b100;
   localparam logic [2:0] c_ST_HALT = 3'b101;

   // ------------------------------------------------------------------------
   // Opcodes
   // ------------------------------------------------------------------------
   localparam logic [5:0] c_OP_ADD   = 6'b000000;
   localparam logic [5:0] c_OP_SUB   = 6'b000001;
   localparam logic [5:0] c_OP_ADDIU = 6'b000010;
   localparam logic [5:0] c_OP_AND   = 6'b010000;
   localparam logic [5:0] c_OP_ANDI  = 6'b010001;
   localparam logic [5:0] c_OP_ORI   = 6'b010010;
   localparam logic [5:0] c_OP_SLL   = 6'b011000;
   localparam logic [5:0] c_OP_SLTI  = 6'b100110;
   localparam logic [5:0] c_OP_SW    = 6'b110000;
   localparam logic [5:0] c_OP_LW    = 6'b110001;
   localparam logic [5:0] c_OP_BEQ   = 6'b110100;
   localparam logic [5:0] c_OP_BNE   = 6'b110101;
   localparam logic [5:0] c_OP_J     = 6'b111000;
   localparam logic [5:0] c_OP_HALT  = 6'b111111;

   // ------------------------------------------------------------------------
   // ALU operation codes
   // ------------------------------------------------------------------------
   localparam logic [2:0] c_ALU_ADD = 3'b000;
   localparam logic [2:0] c_ALU_SUB = 3'b001;
   localparam logic [2:0] c_ALU_SLL = 3'b010;
   localparam logic [2:0] c_ALU_OR  = 3'b011;
   localparam logic [2:0] c_ALU_AND = 3'b100;
   localparam logic [2:0] c_ALU_SLT = 3'b110;

   // ------------------------------------------------------------------------
   // Opcode decode
   // ------------------------------------------------------------------------
   logic w_is_add;
   logic w_is_sub;
   logic w_is_addiu;
   logic w_is_and;
   logic w_is_andi;
   logic w_is_ori;
   logic w_is_sll;
   logic w_is_slti;
   logic w_is_sw;
   logic w_is_lw;
   logic w_is_beq;
   logic w_is_bne;
   logic w_is_j;
   logic w_is_halt;
   logic w_is_alu;      // register-writing arithmetic/logic group (EXE -> WB)
   logic w_is_branch;
   logic w_is_illegal;

   assign w_is_add   = (opcode == c_OP_ADD);
   assign w_is_sub   = (opcode == c_OP_SUB);
   assign w_is_addiu = (opcode == c_OP_ADDIU);
   assign w_is_and   = (opcode == c_OP_AND);
   assign w_is_andi  = (opcode == c_OP_ANDI);
   assign w_is_ori   = (opcode == c_OP_ORI);
   assign w_is_sll   = (opcode == c_OP_SLL);
   assign w_is_slti  = (opcode == c_OP_SLTI);
   assign w_is_sw    = (opcode == c_OP_SW);
   assign w_is_lw    = (opcode == c_OP_LW);
   assign w_is_beq   = (opcode == c_OP_BEQ);
   assign w_is_bne   = (opcode == c_OP_BNE);
   assign w_is_j     = (opcode == c_OP_J);
   assign w_is_halt  = (opcode == c_OP_HALT);

   assign w_is_alu    = w_is_add  | w_is_sub  | w_is_addiu | w_is_and |
                        w_is_andi | w_is_ori  | w_is_sll   | w_is_slti;
   assign w_is_branch = w_is_beq | w_is_bne;

   // Illegal opcodes retire in ID like a no-op: PC advances, nothing written.
   assign w_is_illegal = ~(w_is_alu | w_is_branch | w_is_sw | w_is_lw |
                           w_is_j   | w_is_halt);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   logic [2:0] r_state;
   logic [2:0] w_next_state;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= c_ST_IF;
      end else begin
         r_state <= w_next_state;
      end
   end

   assign State = r_state;

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = c_ST_IF;
      case (r_state)
         c_ST_IF: begin
            w_next_state = c_ST_ID;
         end
         c_ST_ID: begin
            if (w_is_halt) begin
               w_next_state = c_ST_HALT;
            end else if (w_is_j || w_is_illegal) begin
               w_next_state = c_ST_IF;
            end else begin
               w_next_state = c_ST_EXE;
            end
         end
         c_ST_EXE: begin
            if (w_is_lw || w_is_sw) begin
               w_next_state = c_ST_MEM;
            end else if (w_is_alu) begin
               w_next_state = c_ST_WB;
            end else begin
               // branches finish here; anything else is unreachable and
               // recovers by fetching
               w_next_state = c_ST_IF;
            end
         end
         c_ST_MEM: begin
            w_next_state = w_is_lw ? c_ST_WB : c_ST_IF;
         end
         c_ST_WB: begin
            w_next_state = c_ST_IF;
         end
         c_ST_HALT: begin
            // only Reset leaves HALT
            w_next_state = c_ST_HALT;
         end
         default: begin
            // unused encodings fall back to a fresh fetch
            w_next_state = c_ST_IF;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      // state-dependent enables
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;

      case (r_state)
         c_ST_IF: begin
            IRWre = 1'b1;
         end
         c_ST_ID: begin
            PCWre = w_is_j | w_is_illegal;
         end
         c_ST_EXE: begin
            PCWre = w_is_branch;
         end
         c_ST_MEM: begin
            PCWre = w_is_sw;
            mRD   = w_is_lw;
            mWR   = w_is_sw;
         end
         c_ST_WB: begin
            // only lw and the arithmetic/logic group reach WB
            PCWre  = 1'b1;
            RegWre = 1'b1;
         end
         default: begin
            // HALT and unused encodings keep every enable low
         end
      endcase

      // datapath selects depend only on the opcode
      ALUop = c_ALU_ADD;
      if (w_is_sub || w_is_branch) begin
         ALUop = c_ALU_SUB;
      end else if (w_is_sll) begin
         ALUop = c_ALU_SLL;
      end else if (w_is_ori) begin
         ALUop = c_ALU_OR;
      end else if (w_is_and || w_is_andi) begin
         ALUop = c_ALU_AND;
      end else if (w_is_slti) begin
         ALUop = c_ALU_SLT;
      end

      ALUSrcA   = w_is_sll;
      ALUSrcB   = w_is_addiu | w_is_andi | w_is_ori | w_is_slti |
                  w_is_lw    | w_is_sw;
      ExtSel    = ~(w_is_andi | w_is_ori);
      RegDst    = w_is_add | w_is_sub | w_is_and | w_is_sll;
      DBDataSrc = w_is_lw;

      // Branch resolution uses the live zero flag; PCSrc only matters in
      // the cycle PCWre is high.
      PCSrc = 2'b00;
      if (w_is_j) begin
         PCSrc = 2'b10;
      end else if ((w_is_beq && zero) || (w_is_bne && !zero)) begin
         PCSrc = 2'b01;
      end
   end

endmodule
`default_nettype wire
